// File: rtl/down_timer.sv
// Loadable, pausable down-counter with terminal-count Tick.
// Optional auto-reload turns it into a periodic rate divider.
module down_timer #(
   parameter int WIDTH = 8
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             Load,
   input  logic [WIDTH-1:0] LoadValue,
   input  logic             Enable,
   input  logic             AutoReload,
   output logic [WIDTH-1:0] CounterValue,
   output logic             Tick,
   output logic             Busy,
   output logic             Done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [WIDTH-1:0] ZERO = '0;
   localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

   state_t           state_q;
   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] reload_q;
   logic             tick_q;

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q  <= IDLE;
         count_q  <= ZERO;
         reload_q <= ZERO;
         tick_q   <= 1'b0;
      end else if (Load) begin
         count_q  <= LoadValue;
         reload_q <= LoadValue;
         tick_q   <= 1'b0;
         state_q  <= (LoadValue != ZERO) ? RUN : IDLE;
      end else begin
         tick_q <= 1'b0;
         unique case (state_q)
            RUN: begin
               if (Enable) begin
                  if (count_q == ONE) begin
                     tick_q <= 1'b1;
                     if (AutoReload) begin
                        count_q <= reload_q;
                     end else begin
                        count_q <= ZERO;
                        state_q <= DONE;
                     end
                  end else if (count_q != ZERO) begin
                     // Zero guard keeps the count from ever wrapping.
                     count_q <= count_q - ONE;
                  end
               end
            end
            IDLE, DONE: begin
               count_q <= count_q;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign CounterValue = count_q;
   assign Tick         = tick_q;
   assign Busy         = (state_q == RUN);
   assign Done         = (state_q == DONE);

endmodule

// File: tb/tb_down_timer.sv
// Directed + randomized bench for down_timer against a
// rule-level reference model.
module tb_down_timer;

   logic       Clock = 1'b0;
   logic       Reset = 1'b0;
   logic       Load = 1'b0;
   logic [7:0] LoadValue = 8'd0;
   logic       Enable = 1'b0;
   logic       AutoReload = 1'b0;
   logic [7:0] CounterValue;
   logic       Tick, Busy, Done;

   down_timer #(.WIDTH(8)) dut (
      .Clock(Clock), .Reset(Reset), .Load(Load),
      .LoadValue(LoadValue), .Enable(Enable),
      .AutoReload(AutoReload), .CounterValue(CounterValue),
      .Tick(Tick), .Busy(Busy), .Done(Done)
   );

   always #5 Clock = ~Clock;

   int checks = 0;
   int errors = 0;
   int ticks  = 0;

   // Model: phase 0=idle, 1=running, 2=finished.
   int m_phase = 0;
   int m_cnt   = 0;
   int m_per   = 0;
   int m_tick  = 0;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model(input bit r, input bit l, input int v,
                        input bit e, input bit a);
      int fired;
      fired = 0;
      if (r) begin
         m_phase = 0; m_cnt = 0; m_per = 0;
      end else if (l) begin
         m_cnt = v; m_per = v;
         m_phase = (v == 0) ? 0 : 1;
      end else if (m_phase == 1 && e) begin
         if (m_cnt == 1) begin
            fired = 1;
            if (a) m_cnt = m_per;
            else begin m_cnt = 0; m_phase = 2; end
         end else begin
            m_cnt = m_cnt - 1;
         end
      end
      m_tick = fired;
   endtask

   task automatic step(input bit r, input bit l, input int v,
                       input bit e, input bit a, input string tag);
      Reset = r; Load = l; LoadValue = 8'(v);
      Enable = e; AutoReload = a;
      @(posedge Clock);
      model(r, l, v, e, a);
      #1;
      if (Tick === 1'b1) ticks++;
      chk({tag, "_cnt"}, int'(CounterValue), m_cnt);
      chk({tag, "_tick"}, int'(Tick), m_tick);
      chk({tag, "_busy"}, int'(Busy), int'(m_phase == 1));
      chk({tag, "_done"}, int'(Done), int'(m_phase == 2));
   endtask

   initial begin
      int seq[6];
      #1;
      // Reset then idle with Enable high
      step(1, 0, 0, 1, 0, "rst");
      step(1, 0, 0, 1, 0, "rst");
      chk("rst_cv", int'(CounterValue), 0);
      for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 0, "idle");
      chk("idle_busy", int'(Busy), 0);

      // One-shot of 5
      seq = '{4, 3, 2, 1, 0, 0};
      step(0, 1, 5, 1, 0, "os_ld");
      chk("os_ld_cv", int'(CounterValue), 5);
      ticks = 0;
      for (int i = 0; i < 6; i++) begin
         step(0, 0, 0, 1, 0, "os");
         chk("os_seq", int'(CounterValue), seq[i]);
         if (i == 4) chk("os_tick", int'(Tick), 1);
      end
      chk("os_ticks", ticks, 1);
      chk("os_done", int'(Done), 1);

      // Periodic 3
      step(0, 1, 3, 1, 1, "per_ld");
      ticks = 0;
      for (int i = 0; i < 12; i++) step(0, 0, 0, 1, 1, "per");
      chk("per_ticks", ticks, 4);
      chk("per_busy", int'(Busy), 1);

      // Pause
      step(0, 1, 4, 1, 0, "pz_ld");
      ticks = 0;
      seq = '{3, 3, 3, 2, 1, 0};
      for (int i = 0; i < 6; i++) begin
         step(0, 0, 0, (i == 1 || i == 2) ? 1'b0 : 1'b1, 0, "pz");
         chk("pz_seq", int'(CounterValue), seq[i]);
      end
      chk("pz_ticks", ticks, 1);

      // Boundaries
      step(0, 1, 0, 1, 1, "ld0");
      ticks = 0;
      for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 1, "ld0");
      chk("ld0_ticks", ticks, 0);

      step(0, 1, 1, 1, 1, "ld1");
      ticks = 0;
      for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 1, "ld1");
      chk("ld1_ticks", ticks, 5);
      chk("ld1_cv", int'(CounterValue), 1);

      step(0, 1, 255, 1, 1, "ldff");
      ticks = 0;
      for (int i = 0; i < 254; i++) step(0, 0, 0, 1, 1, "ldff");
      chk("ldff_early", ticks, 0);
      step(0, 0, 0, 1, 1, "ldff");
      chk("ldff_first", int'(Tick), 1);
      for (int i = 0; i < 255; i++) step(0, 0, 0, 1, 1, "ldff");
      chk("ldff_ticks", ticks, 2);

      // Load collides with terminal count
      step(0, 1, 2, 1, 0, "col_ld");
      step(0, 0, 0, 1, 0, "col");
      step(0, 1, 7, 1, 0, "col_hit");
      chk("col_cv", int'(CounterValue), 7);
      chk("col_tick", int'(Tick), 0);

      // Reset mid-run at count 2
      step(0, 1, 5, 1, 1, "rm_ld");
      for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 1, "rm");
      chk("rm_pre", int'(CounterValue), 2);
      step(1, 1, 9, 1, 1, "rm_rst");
      chk("rm_cv", int'(CounterValue), 0);
      for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 1, "rm_post");
      chk("rm_idle", int'(Busy), 0);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         bit r, l, e, a;
         int v;
         r = ($urandom_range(0, 40) == 0);
         l = ($urandom_range(0, 9) == 0);
         e = ($urandom_range(0, 3) != 0);
         a = $urandom_range(0, 1) != 0;
         v = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 255))
                                           : int'($urandom_range(0, 6));
         step(r, l, v, e, a, "rnd");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
